alu_input_ctrl: RTL and testbench

ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

---
 rtl/alu_input_ctrl.sv | 95 +++++++++
 tb/tb_alu_input_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_input_ctrl.sv
// Button front end and mode/operand FSM for a small ALU board: sync + debounce per button,
// press events after DEB+3 edges, FSM acts one edge later; no backpressure (free-running).
module alu_input_ctrl #(
    parameter int n   = 4,
    parameter int DEB = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         selector,
    input  logic         start,
    input  logic         clear,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [3:0]   modo,
    output logic [n-1:0] op_a,
    output logic [n-1:0] op_b,
    output logic         run,
    output logic         start_pulse
);

    localparam int CW = $clog2(DEB + 1);

    typedef enum logic {SELECT, HOLD} state_t;

    // Bit order everywhere below: [0]=selector, [1]=start, [2]=clear.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [2:0]    press;
    logic [CW-1:0] cnt [3];
    state_t        state;

    assign raw = {clear, start, selector};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            // Only falling (press) transitions of the debounced level produce an event.
            press <= deb_d & ~deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SELECT;
            modo        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            // Priority clear > selector > start; losers are dropped.
            if (press[2]) begin
                state <= SELECT;
                modo  <= '0;
                op_a  <= '0;
                op_b  <= '0;
            end else if (press[0]) begin
                state <= SELECT;
                modo  <= (modo >= 4'd9) ? 4'd0 : modo + 4'd1;
            end else if (press[1]) begin
                state       <= HOLD;
                op_a        <= A;
                op_b        <= B;
                start_pulse <= 1'b1;
            end
        end
    end

    assign run = (state == HOLD);

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Bench for alu_input_ctrl: window-based reference model compared every cycle,
// plus directed button sequences with literal expectations.
module tb_alu_input_ctrl;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         selector = 1'b1;
    logic         start    = 1'b1;
    logic         clear    = 1'b1;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [3:0]   modo;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         run;
    logic         start_pulse;

    int checks = 0;
    int errors = 0;

    alu_input_ctrl #(.n(N), .DEB(DEB)) dut (
        .clk(clk), .reset(reset), .selector(selector), .start(start), .clear(clear),
        .A(A), .B(B), .modo(modo), .op_a(op_a), .op_b(op_b), .run(run),
        .start_pulse(start_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a button's level flips once the last DEB synchronized samples
    // all disagree with it; a press is acted on two edges after the level falls.
    logic [DEB:0] hist [3];
    logic [2:0]   lvl, p0, p1, act, rawv;
    logic         flip;
    int           m_modo;
    logic [N-1:0] m_opa, m_opb;
    logic         m_run, m_sp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 3; b++) hist[b] = '1;
            lvl = '1; p0 = '0; p1 = '0;
            m_modo = 0; m_opa = '0; m_opb = '0; m_run = 1'b0; m_sp = 1'b0;
        end else begin
            rawv = {clear, start, selector};
            act  = p1;
            p1   = p0;
            for (int b = 0; b < 3; b++) begin
                flip = 1'b1;
                for (int k = 1; k <= DEB; k++) if (hist[b][k] == lvl[b]) flip = 1'b0;
                p0[b] = flip && lvl[b];
                if (flip) lvl[b] = ~lvl[b];
                for (int k = DEB; k >= 1; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = rawv[b];
            end
            m_sp = 1'b0;
            if (act[2]) begin
                m_modo = 0; m_opa = '0; m_opb = '0; m_run = 1'b0;
            end else if (act[0]) begin
                m_modo = (m_modo + 1) % 10; m_run = 1'b0;
            end else if (act[1]) begin
                m_opa = A; m_opb = B; m_sp = 1'b1; m_run = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_modo", modo, m_modo);
            chk("model_op_a", op_a, m_opa);
            chk("model_op_b", op_b, m_opb);
            chk("model_run", run, m_run);
            chk("model_start_pulse", start_pulse, m_sp);
            chk("modo_range", modo <= 4'd9, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // m[0]=selector, m[1]=start, m[2]=clear; returns start_pulse cycles seen.
    task automatic press(input logic [2:0] m, input int low, output int pulses);
        pulses = 0;
        if (m[0]) selector = 1'b0;
        if (m[1]) start = 1'b0;
        if (m[2]) clear = 1'b0;
        repeat (low) begin tick(); pulses += int'(start_pulse); end
        selector = 1'b1; start = 1'b1; clear = 1'b1;
        repeat (DEB + 6) begin tick(); pulses += int'(start_pulse); end
    endtask

    int p;

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_modo", modo, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_run", run, 0);
        chk("rst_start_pulse", start_pulse, 0);
        reset = 1'b0;
        tick();

        // Held selector: one advance at edge 8 after first low sample.
        selector = 1'b0;
        repeat (7) tick();
        chk("hold_sel_edge7", modo, 0);
        tick();
        chk("hold_sel_edge8", modo, 1);
        repeat (12) tick();
        chk("hold_sel_after20", modo, 1);
        chk("hold_sel_run", run, 0);
        selector = 1'b1;
        repeat (DEB + 6) tick();

        press(3'b100, DEB + 4, p);
        chk("clear_to_0", modo, 0);

        for (int i = 1; i <= 10; i++) begin
            press(3'b001, DEB + 4, p);
            chk("sel_step", modo, i % 10);
        end

        A = 4'b1010; B = 4'b0011;
        press(3'b010, DEB + 4, p);
        chk("start_pulse_count", p, 1);
        chk("start_op_a", op_a, 4'b1010);
        chk("start_op_b", op_b, 4'b0011);
        chk("start_run", run, 1);
        A = 4'b0000;
        repeat (5) tick();
        chk("op_a_retained", op_a, 4'b1010);

        // Glitch of 3 cycles: ignored.
        selector = 1'b0; repeat (3) tick();
        selector = 1'b1; repeat (DEB + 6) tick();
        chk("glitch_modo", modo, 0);
        chk("glitch_run", run, 1);
        // Bounce low3/high1/low10: exactly one advance.
        selector = 1'b0; repeat (3) tick();
        selector = 1'b1; tick();
        selector = 1'b0; repeat (10) tick();
        selector = 1'b1; repeat (DEB + 6) tick();
        chk("bounce_modo", modo, 1);
        chk("bounce_run", run, 0);

        repeat (4) press(3'b001, DEB + 4, p);
        press(3'b010, DEB + 4, p);
        chk("hold5_modo", modo, 5);
        chk("hold5_run", run, 1);
        press(3'b101, DEB + 4, p);
        chk("coincide_modo", modo, 0);
        chk("coincide_op_a", op_a, 0);
        chk("coincide_op_b", op_b, 0);
        chk("coincide_run", run, 0);
        press(3'b001, DEB + 4, p);
        chk("after_clear_sel", modo, 1);

        // Reset two cycles before a start event, button kept low.
        A = 4'b0110; B = 4'b1001;
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("midrst_modo", modo, 0);
        chk("midrst_run", run, 0);
        chk("midrst_start_pulse", start_pulse, 0);
        tick();
        reset = 1'b0;
        p = 0;
        repeat (DEB + 3) begin tick(); p += int'(start_pulse); end
        chk("postrst_no_early_pulse", p, 0);
        chk("postrst_op_a_zero", op_a, 0);
        tick();
        chk("postrst_pulse", start_pulse, 1);
        chk("postrst_op_a", op_a, 4'b0110);
        chk("postrst_op_b", op_b, 4'b1001);
        chk("postrst_run", run, 1);
        p = 0;
        repeat (10) begin tick(); p += int'(start_pulse); end
        chk("postrst_single_pulse", p, 0);
        start = 1'b1;
        repeat (DEB + 6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
